// File: rtl/prisoner_box.sv
// Guard-keyed single-slot slip box: a correct-key load seals a slip, and a
// prisoner read shows it for one cycle. Repeated wrong keys lock the box until reset.
module prisoner_box #(
    parameter logic [31:0] GUARD_KEY    = 32'hDEADBEEF,
    parameter int unsigned MAX_BAD_KEYS = 3
) (
    output logic [7:0]  output_data,
    input  logic [7:0]  input_data,
    input  logic [31:0] guard_key,
    input  logic        load,
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_enable
);

    localparam int unsigned SLIP_W = 8;
    localparam int unsigned CNT_W  = 4;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BAD_KEYS);

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        SEALED = 2'd1,
        OPENED = 2'd2,
        LOCKED = 2'd3
    } state_t;

    state_t            state;
    logic [SLIP_W-1:0] slip;
    logic [CNT_W-1:0]  bad_keys;
    logic              has_slip;
    logic [CNT_W-1:0]  bad_keys_inc;
    logic              key_ok;

    assign bad_keys_inc = bad_keys + CNT_W'(1);
    assign key_ok       = (guard_key == GUARD_KEY);

    // Load takes priority over read; output_data closes on any cycle without a read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= EMPTY;
            slip        <= '0;
            bad_keys    <= '0;
            has_slip    <= 1'b0;
            output_data <= '0;
        end else begin
            output_data <= '0;
            if (load) begin
                if (state != LOCKED) begin
                    if (key_ok) begin
                        slip     <= input_data;
                        state    <= SEALED;
                        bad_keys <= '0;
                        has_slip <= 1'b1;
                    end else begin
                        if (bad_keys < MAX_CNT) begin
                            bad_keys <= bad_keys_inc;
                        end
                        if (bad_keys_inc >= MAX_CNT) begin
                            state <= LOCKED;
                        end
                    end
                end
            end else if (rd_enable) begin
                case (state)
                    SEALED: begin
                        output_data <= slip;
                        state       <= OPENED;
                    end
                    OPENED: output_data <= slip;
                    LOCKED: output_data <= has_slip ? slip : SLIP_W'(0);
                    default: output_data <= '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prisoner_box.sv
// Directed-vector bench for prisoner_box with hand-computed expected slips.
module tb_prisoner_box;

    localparam logic [31:0] KEY = 32'hDEADBEEF;
    localparam logic [31:0] BAD = 32'h12345678;

    logic [7:0]  output_data;
    logic [7:0]  input_data;
    logic [31:0] guard_key;
    logic        load;
    logic        clk;
    logic        rst;
    logic        rd_enable;

    int vectors     = 0;
    int miscompares = 0;

    prisoner_box #(.GUARD_KEY(32'hDEADBEEF), .MAX_BAD_KEYS(3)) dut (
        .output_data(output_data),
        .input_data (input_data),
        .guard_key  (guard_key),
        .load       (load),
        .clk        (clk),
        .rst        (rst),
        .rd_enable  (rd_enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // Drive one edge worth of inputs, then sample just after the edge.
    task automatic step(input logic ld, input logic rd, input logic [31:0] key,
                        input logic [7:0] data);
        load       = ld;
        rd_enable  = rd;
        guard_key  = key;
        input_data = data;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        load = 1'b0; rd_enable = 1'b0; guard_key = KEY; input_data = 8'h00;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; rd_enable = 1'b0; guard_key = '0; input_data = '0;
        @(posedge clk);
        #1;
        check("reset_out", output_data, 8'h00);
        rst = 1'b0;

        // Load then read
        step(1, 0, KEY, 8'hAB);
        check("load_cycle_closed", output_data, 8'h00);
        step(0, 1, 32'h0, 8'h00);
        check("read_ab", output_data, 8'hAB);
        step(0, 0, 32'h0, 8'h00);
        check("close_after_read", output_data, 8'h00);

        // Async reset mid-read clears output immediately
        step(0, 1, 32'h0, 8'h00);
        check("read_ab_again", output_data, 8'hAB);
        #2;
        guard_key = KEY;
        rst = 1'b1;
        #1;
        check("async_reset_out", output_data, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(0, 1, 32'h0, 8'h00);
        check("read_after_reset_empty", output_data, 8'h00);

        // Wrong key then correct key
        step(1, 0, BAD, 8'h55);
        step(0, 1, 32'h0, 8'h00);
        check("wrong_key_read", output_data, 8'h00);
        step(1, 0, KEY, 8'h55);
        step(0, 1, 32'h0, 8'h00);
        check("right_key_read_55", output_data, 8'h55);

        // Lockout while empty
        do_reset();
        step(1, 0, BAD, 8'h01);
        step(1, 0, BAD, 8'h02);
        step(1, 0, BAD, 8'h03);
        step(1, 0, KEY, 8'h77);
        step(0, 1, 32'h0, 8'h00);
        check("locked_empty_read", output_data, 8'h00);
        do_reset();
        step(1, 0, KEY, 8'h77);
        step(0, 1, 32'h0, 8'h00);
        check("unlocked_read_77", output_data, 8'h77);

        // Lockout after a seal keeps the old slip readable and ignores reloads
        step(1, 0, KEY, 8'h99);
        step(1, 0, BAD, 8'h00);
        step(1, 0, BAD, 8'h00);
        step(1, 0, BAD, 8'h00);
        step(1, 0, KEY, 8'h33);
        step(0, 1, 32'h0, 8'h00);
        check("locked_sealed_read", output_data, 8'h99);

        // Two wrong keys below threshold, correct key clears the count
        do_reset();
        step(1, 0, BAD, 8'h00);
        step(1, 0, BAD, 8'h00);
        step(1, 0, KEY, 8'h44);
        step(1, 0, BAD, 8'h00);
        step(1, 0, BAD, 8'h00);
        step(0, 1, 32'h0, 8'h00);
        check("count_cleared_read", output_data, 8'h44);
        step(1, 0, KEY, 8'h45);
        step(0, 1, 32'h0, 8'h00);
        check("not_locked_reload", output_data, 8'h45);

        // Simultaneous load and read
        step(1, 0, KEY, 8'h11);
        step(1, 1, KEY, 8'h22);
        check("load_read_same_edge", output_data, 8'h00);
        step(0, 1, 32'h0, 8'h00);
        check("read_after_overlap", output_data, 8'h22);

        // Overwrite and repeat read
        step(1, 0, KEY, 8'hAB);
        step(0, 1, 32'h0, 8'h00);
        check("repeat_read_1", output_data, 8'hAB);
        step(0, 1, 32'h0, 8'h00);
        check("repeat_read_2", output_data, 8'hAB);
        step(1, 0, KEY, 8'hCD);
        step(0, 1, 32'h0, 8'h00);
        check("overwrite_read_cd", output_data, 8'hCD);
        step(0, 0, 32'h0, 8'h00);
        check("final_close", output_data, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
